snes_controller_reader: RTL and testbench
=========================================

Name: snes_controller_reader

Overview:
- Polls an SNES game pad over its native 3-wire serial interface: latch out, clock out, serial data in.
- Deserialises the 16-bit response into registered active-low button signals, which feed the button-to-colour decoder and sprite logic.
- Owns all pad timing: the poll rate, the 12 µs latch pulse and the 16 clock pulses.

Parameters:
- T6, 300, clk cycles per 6 µs half-period of the pad clock (50 MHz system clock).
- POLL_TICKS, 833333, clk cycles between successive latch rising edges (60 Hz). Must satisfy POLL_TICKS >= 34*T6+2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- snes_data  in  1  serial data from pad, active-low; asynchronous to clk.
- snes_latch  out  1  latch to pad, active-high.
- snes_clk  out  1  clock to pad; idles high.
- btn_n  out  12  active-low buttons, 0 = pressed. Bit order: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
- ctrl_ok  out  1  last frame's trailer bits 12..15 all read 1.
- frame_valid  out  1  one-cycle pulse when btn_n/ctrl_ok are updated.

Behaviour:
- Reset is asynchronous and active-low, effective immediately at any point, including mid-frame. On reset:
  - snes_latch=0, snes_clk=1, btn_n=12'hFFF, ctrl_ok=0, frame_valid=0.
  - poll counter=0, shift register=16'hFFFF, FSM=IDLE.
- All outputs are registered; no combinational paths from inputs to outputs.
- snes_data passes through a 2-flop synchroniser (reset value 1) before use.
- Poll counter:
  - Free-running 0..POLL_TICKS-1, wraps to 0.
  - Issues a start strobe on the cycle it equals POLL_TICKS-1.
  - First latch rises POLL_TICKS cycles after rst_n deasserts.
- FSM states:
  - IDLE: snes_latch=0, snes_clk=1. On start strobe -> LATCH.
  - LATCH: snes_latch=1 for exactly 2*T6 cycles; then bit index k=0 -> CLK_LO.
  - CLK_LO: snes_clk=0 for T6 cycles. On the last cycle, the synchronised data is stored into shift bit k -> CLK_HI.
  - CLK_HI: snes_clk=1 for T6 cycles. The pad shifts on this rising edge. If k=15 -> DONE; else k=k+1 -> CLK_LO.
  - DONE (1 cycle):
    - ctrl_ok = &shift[15:12].
    - btn_n = ctrl_ok ? shift[11:0] : 12'hFFF.
    - frame_valid=1 this cycle only.
    - Shift register reloads 16'hFFFF -> IDLE.
- Bit 0 (B) is valid from the latch falling edge. Each later bit is valid from the preceding snes_clk rising edge. Sampling at the end of each low phase tolerates the 2-cycle synchroniser delay.
- Frame length: 2*T6 + 32*T6 + 1 cycles.
  - The parameter constraint guarantees the FSM is in IDLE before the next start strobe.
  - A strobe arriving outside IDLE is ignored; it cannot occur within the legal parameter range.
- Exactly 16 snes_clk falling edges per frame. snes_clk never toggles while snes_latch=1.
- btn_n and ctrl_ok hold between DONE cycles; no partial-frame values are ever visible.
- Unplugged pad with pull-up reads all 1s: ctrl_ok=1, btn_n=FFF. With pull-down: ctrl_ok=0, btn_n=FFF.

Test Plan:
- Bench settings: T6=4, POLL_TICKS=200. Pad model loads its word on snes_latch high and shifts on the snes_clk rising edge.
- Reset/timing: release rst_n, no presses -> outputs hold reset values. snes_latch rises at cycle 200 for 8 cycles. frame_valid pulses 137 cycles after the latch rise with btn_n=FFF, ctrl_ok=1.
- Single button: pad word 16'hFEFF (A pressed) -> btn_n=12'hEFF, ctrl_ok=1, exactly one frame_valid pulse per 200 cycles.
- Multiple buttons: Select+Start pressed (word 16'hFFF3) -> btn_n=12'hFFF3[11:0]=FF3. Next frame with all released -> FFF.
- Bad trailer: snes_data held 0 -> ctrl_ok=0, btn_n=FFF, frame_valid still pulses.
- Mid-frame reset: assert rst_n=0 during bit 7 CLK_LO -> same cycle snes_clk=1, snes_latch=0, btn_n=FFF, ctrl_ok=0, no frame_valid. After release, next latch rises exactly 200 cycles later.
- Waveform checks over 3 frames:
  - 16 snes_clk falls per frame.
  - Every low and high phase is 4 cycles.
  - Latch rising edges are 200 cycles apart.
  - No snes_clk activity while snes_latch=1.

Source files
------------

// File: rtl/snes_controller_reader.sv
// snes_controller_reader: polls an SNES pad over latch/clock/data and deserialises
// its 16-bit response into registered active-low buttons.
module snes_controller_reader #(
  parameter int T6 = 300,
  parameter int POLL_TICKS = 833333
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [11:0] btn_n,
  output logic        ctrl_ok,
  output logic        frame_valid
);
  localparam int PW = $clog2(POLL_TICKS);
  localparam int HW = $clog2(2 * T6);
  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;
  state_t state;
  logic [PW-1:0] poll;
  logic [HW-1:0] ph;
  logic [3:0] k;
  logic [15:0] shift;
  logic [1:0] sync;
  logic start, ph_end;
  assign start = poll == PW'(POLL_TICKS - 1);
  assign ph_end = ph == (state == LATCH ? HW'(2 * T6 - 1) : HW'(T6 - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], snes_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) poll <= '0;
    else poll <= start ? '0 : poll + 1'b1;
  // Data is sampled on the last low-phase cycle, well after the synchroniser settles.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      ph          <= '0;
      k           <= '0;
      shift       <= 16'hFFFF;
      snes_latch  <= 1'b0;
      snes_clk    <= 1'b1;
      btn_n       <= 12'hFFF;
      ctrl_ok     <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      ph <= ph + 1'b1;
      case (state)
        IDLE: if (start) begin
          state      <= LATCH;
          ph         <= '0;
          snes_latch <= 1'b1;
        end
        LATCH: if (ph_end) begin
          state      <= CLK_LO;
          ph         <= '0;
          k          <= '0;
          snes_latch <= 1'b0;
          snes_clk   <= 1'b0;
        end
        CLK_LO: if (ph_end) begin
          state    <= CLK_HI;
          ph       <= '0;
          shift[k] <= sync[1];
          snes_clk <= 1'b1;
        end
        CLK_HI: if (ph_end) begin
          state    <= k == 4'd15 ? DONE : CLK_LO;
          ph       <= '0;
          k        <= k + 1'b1;
          snes_clk <= k == 4'd15;
        end
        DONE: begin
          state       <= IDLE;
          ctrl_ok     <= &shift[15:12];
          btn_n       <= &shift[15:12] ? shift[11:0] : 12'hFFF;
          frame_valid <= 1'b1;
          shift       <= 16'hFFFF;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_snes_controller_reader.sv
// tb_snes_controller_reader: pad model plus scoreboard of expected frames and
// waveform timing monitor for snes_controller_reader.
module tb_snes_controller_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snes_data;
  logic snes_latch, snes_clk, ctrl_ok, frame_valid;
  logic [11:0] btn_n;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rel_cyc = 0;
  logic [15:0] word = 16'hFFFF;
  logic hold0 = 1'b0;
  logic [15:0] pad_sh = 16'hFFFF;
  int pad_idx = 16;
  typedef struct {logic [11:0] btn; logic ok; int c;} exp_t;
  exp_t q[$];

  snes_controller_reader #(.T6(4), .POLL_TICKS(200)) dut (
    .clk(clk), .rst_n(rst_n), .snes_data(snes_data), .snes_latch(snes_latch),
    .snes_clk(snes_clk), .btn_n(btn_n), .ctrl_ok(ctrl_ok), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pad: loads on latch, presents bit 0 first, shifts on each clock rise.
  always @(posedge snes_latch) begin
    pad_sh = word;
    pad_idx = 0;
  end
  always @(posedge snes_clk) if (!snes_latch && pad_idx < 16) pad_idx++;
  assign snes_data = hold0 ? 1'b0 : (pad_idx < 16 ? pad_sh[pad_idx] : 1'b1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pushes at latch rise, pops at frame_valid; checks pad timing.
  initial begin
    logic pl = 1'b0, ps = 1'b1;
    int last_rise = -1, last_fv = -1, last_edge = 0, falls = 0;
    logic [15:0] w;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        last_rise = -1;
        last_fv = -1;
        falls = 0;
        pl = 1'b0;
        ps = 1'b1;
      end else begin
        if (snes_latch && !pl) begin
          if (last_rise >= 0) check("latch_period", cyc - last_rise, 200);
          else check("latch_first", cyc - rel_cyc, 200);
          last_rise = cyc;
          falls = 0;
          w = hold0 ? 16'h0000 : word;
          e.ok = &w[15:12];
          e.btn = e.ok ? w[11:0] : 12'hFFF;
          e.c = cyc;
          q.push_back(e);
        end
        if (!snes_latch && pl) check("latch_width", cyc - last_rise, 8);
        if (snes_clk != ps) begin
          check("clk_quiet_in_latch", snes_latch, 0);
          if (!snes_clk) begin
            if (falls > 0) check("hi_phase", cyc - last_edge, 4);
            falls++;
          end else check("lo_phase", cyc - last_edge, 4);
          last_edge = cyc;
        end
        if (frame_valid) begin
          if (last_fv >= 0) check("fv_period", cyc - last_fv, 200);
          last_fv = cyc;
          if (q.size() == 0) check("fv_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            check("btn_n", btn_n, e.btn);
            check("ctrl_ok", ctrl_ok, e.ok);
            check("fv_latency", cyc - e.c, 137);
            check("clk_falls", falls, 16);
          end
        end
        pl = snes_latch;
        ps = snes_clk;
      end
    end
  end

  task automatic wait_fv();
    int n = 0;
    while (!frame_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!frame_valid) check("fv_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int n = 0, f = 0;
    logic pc;
    repeat (3) @(negedge clk);
    check("rst_latch", snes_latch, 0);
    check("rst_clk", snes_clk, 1);
    check("rst_btn", btn_n, 12'hFFF);
    check("rst_ok", ctrl_ok, 0);
    check("rst_fv", frame_valid, 0);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
    repeat (100) @(negedge clk);
    check("idle_btn", btn_n, 12'hFFF);
    check("idle_ok", ctrl_ok, 0);
    check("idle_latch", snes_latch, 0);
    wait_fv(); word = 16'hFEFF;
    wait_fv(); word = 16'hFFF3;
    wait_fv(); word = 16'hFFFF;
    wait_fv(); hold0 = 1'b1;
    wait_fv(); hold0 = 1'b0; word = 16'hFFF3;
    wait_fv(); word = 16'hFFFF;
    while (!snes_latch && n < 400) begin
      @(negedge clk);
      n++;
    end
    pc = snes_clk;
    while (f < 8 && n < 800) begin
      @(negedge clk);
      n++;
      if (pc && !snes_clk) f++;
      pc = snes_clk;
    end
    check("bit7_reached", f, 8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_clk", snes_clk, 1);
    check("mid_rst_latch", snes_latch, 0);
    check("mid_rst_btn", btn_n, 12'hFFF);
    check("mid_rst_ok", ctrl_ok, 0);
    check("mid_rst_fv", frame_valid, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
    wait_fv();
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
